// File: rtl/adder_sched_pkg.sv
// Shared definitions for the round-robin adder scheduler: default widths,
// the requester-index width helper and the response record type.
package adder_sched_pkg;

  localparam int NREQ_DEF  = 4;
  localparam int OP_W_DEF  = 4;
  localparam int RES_W_DEF = 8;
  localparam int CNT_W_DEF = 16;

  // Index width for n requesters; a single requester still needs one bit.
  function automatic int id_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  localparam int ID_W_DEF = id_w(NREQ_DEF);

  // One response as clients see it at the default configuration.
  typedef struct packed {
    logic [ID_W_DEF-1:0]  id;
    logic [RES_W_DEF-1:0] sum;
  } rsp_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requesting index at or
// after ptr, searching upward and wrapping from N-1 back to 0.
module rr_arbiter
  import adder_sched_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = id_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx
);

  logic found;

  // Rotating priority scan; the first hit wins and later hits are ignored.
  always_comb begin
    // NOTE: every output gets a default before the loop so no path leaves a
    // value unassigned, which would otherwise infer a latch.
    grant = '0;
    idx   = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      int k;
      k = (int'(ptr) + i) % N;
      if (!found && req[k]) begin
        found    = 1'b1;
        grant[k] = 1'b1;
        idx      = IW'(k);
      end
    end
  end

endmodule

// File: rtl/adder_rr_scheduler.sv
// Shares one registered adder between NREQ requesters. A round-robin arbiter
// selects one requester per cycle; its zero-extended sum is registered and
// returned with the requester index over a valid/ready response channel.
module adder_rr_scheduler
  import adder_sched_pkg::*;
#(
  parameter int  NREQ  = NREQ_DEF,
  parameter int  OP_W  = OP_W_DEF,
  parameter int  RES_W = RES_W_DEF,
  parameter int  CNT_W = CNT_W_DEF,
  localparam int ID_W  = id_w(NREQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [NREQ*OP_W-1:0] req_a,
  input  logic [NREQ*OP_W-1:0] req_b,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [ID_W-1:0]    rsp_id,
  output logic [RES_W-1:0]   rsp_sum,
  output logic [CNT_W-1:0]   issue_cnt
);

  logic [NREQ-1:0]  grant;
  logic [ID_W-1:0]  gnt_idx;
  logic [ID_W-1:0]  ptr;
  logic [ID_W-1:0]  ptr_nxt;
  logic             stall;
  logic             accept;
  logic [OP_W-1:0]  a_sel;
  logic [OP_W-1:0]  b_sel;
  logic [RES_W-1:0] sum_nxt;

  rr_arbiter #(.N(NREQ), .IW(ID_W)) u_arb (
    .req   (req_valid),
    .ptr   (ptr),
    .grant (grant),
    .idx   (gnt_idx)
  );

  // A held response blocks new accepts; nothing is accepted while in reset.
  assign stall     = rsp_valid & ~rsp_ready;
  assign req_ready = grant & {NREQ{~stall & rst_n}};
  assign accept    = |req_ready;

  // Operand mux and adder; the select depends only on the grant index.
  assign a_sel   = req_a[gnt_idx*OP_W +: OP_W];
  assign b_sel   = req_b[gnt_idx*OP_W +: OP_W];
  assign sum_nxt = RES_W'(a_sel) + RES_W'(b_sel);
  assign ptr_nxt = (gnt_idx == ID_W'(NREQ - 1)) ? '0 : gnt_idx + ID_W'(1);

  // Response register, round-robin pointer and issue counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_sum   <= '0;
      ptr       <= '0;
      issue_cnt <= '0;
    end else if (accept) begin
      // NOTE: state uses non-blocking assignments so every register samples
      // pre-edge values regardless of statement order.
      rsp_valid <= 1'b1;
      rsp_id    <= gnt_idx;
      rsp_sum   <= sum_nxt;
      ptr       <= ptr_nxt;
      issue_cnt <= issue_cnt + CNT_W'(1);
    end else if (!stall) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_adder_rr_scheduler.sv
// Self-checking bench for adder_rr_scheduler: directed scenarios plus
// randomized traffic against a transaction-level reference model.
module tb_adder_rr_scheduler;

  localparam int NREQ = 4;
  localparam int OP_W = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [NREQ-1:0]  req_valid;
  logic [NREQ-1:0]  req_ready;
  logic [NREQ*OP_W-1:0] req_a;
  logic [NREQ*OP_W-1:0] req_b;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [1:0]       rsp_id;
  logic [7:0]       rsp_sum;
  logic [15:0]      issue_cnt;

  logic [OP_W-1:0] op_a [NREQ];
  logic [OP_W-1:0] op_b [NREQ];

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  bit m_valid;
  int m_id, m_sum, m_ptr, m_cnt;
  int wait_acc [NREQ];
  int max_wait;

  adder_rr_scheduler dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_sum   (rsp_sum),
    .issue_cnt (issue_cnt)
  );

  always #5 clk = ~clk;

  always_comb begin
    req_a = '0;
    req_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_a[i*OP_W +: OP_W] = op_a[i];
      req_b[i*OP_W +: OP_W] = op_b[i];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_valid = 0; m_id = 0; m_sum = 0; m_ptr = 0; m_cnt = 0;
    for (int i = 0; i < NREQ; i++) wait_acc[i] = 0;
  endtask

  // One clock cycle: inputs already applied after a falling edge.
  task automatic cycle(input bit chk);
    int sel;
    bit stall;
    logic [NREQ-1:0] exp_ready;
    int obs;
    #1;
    sel = -1;
    for (int k = 0; k < NREQ; k++) begin
      int j;
      j = (m_ptr + k) % NREQ;
      if (sel < 0 && req_valid[j]) sel = j;
    end
    stall = m_valid && !rsp_ready;
    exp_ready = '0;
    if (!stall && sel >= 0) exp_ready[sel] = 1'b1;
    if (chk) check("req_ready", 32'(req_ready), 32'(exp_ready));
    // Fairness bookkeeping from what the DUT actually granted.
    obs = -1;
    for (int i = 0; i < NREQ; i++) if (req_ready[i]) obs = i;
    if (obs >= 0) begin
      for (int i = 0; i < NREQ; i++) begin
        if (i == obs) wait_acc[i] = 0;
        else if (req_valid[i]) begin
          wait_acc[i]++;
          if (wait_acc[i] > max_wait) max_wait = wait_acc[i];
        end else wait_acc[i] = 0;
      end
    end else begin
      for (int i = 0; i < NREQ; i++) if (!req_valid[i]) wait_acc[i] = 0;
    end
    @(posedge clk);
    if (!stall && sel >= 0) begin
      m_valid = 1;
      m_id    = sel;
      m_sum   = int'(op_a[sel]) + int'(op_b[sel]);
      m_ptr   = (sel + 1) % NREQ;
      m_cnt   = (m_cnt + 1) % 65536;
    end else if (!stall) begin
      m_valid = 0;
    end
    #1;
    if (chk) begin
      check("rsp_valid", 32'(rsp_valid), 32'(m_valid));
      check("rsp_id",    32'(rsp_id),    32'(m_id));
      check("rsp_sum",   32'(rsp_sum),   32'(m_sum));
      check("issue_cnt", 32'(issue_cnt), 32'(m_cnt));
    end
    @(negedge clk);
  endtask

  task automatic set_ops(input int i, input int a, input int b);
    op_a[i] = OP_W'(a);
    op_b[i] = OP_W'(b);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    check({tag, "_rsp_id"},    32'(rsp_id),    32'd0);
    check({tag, "_rsp_sum"},   32'(rsp_sum),   32'd0);
    check({tag, "_issue_cnt"}, 32'(issue_cnt), 32'd0);
    check({tag, "_req_ready"}, 32'(req_ready), 32'd0);
  endtask

  initial begin
    max_wait  = 0;
    rst_n     = 1'b0;
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    for (int i = 0; i < NREQ; i++) set_ops(i, i, i + 1);
    model_reset();

    // Power-on reset with requests pending
    #2;
    check_reset_outputs("por");
    @(negedge clk);
    @(negedge clk);
    check_reset_outputs("por_held");
    rst_n = 1'b1;
    req_valid = '0;

    // Single requester 1: 3 + 5
    set_ops(1, 3, 5);
    req_valid = 4'b0010;
    cycle(1);
    check("single_sum", 32'(rsp_sum), 32'h08);
    req_valid = '0;
    cycle(1);

    // All valid held: order follows pointer around the ring
    req_valid = 4'b1111;
    for (int n = 0; n < 5; n++) cycle(1);

    // Backpressure for three cycles, then release
    rsp_ready = 1'b0;
    for (int n = 0; n < 3; n++) cycle(1);
    rsp_ready = 1'b1;
    cycle(1);
    cycle(1);

    // Maximum operands
    req_valid = '0;
    cycle(1);
    set_ops(2, 15, 15);
    req_valid = 4'b0100;
    cycle(1);
    check("max_sum", 32'(rsp_sum), 32'h1E);

    // Pointer now at 3: wrap from 3 to 0
    req_valid = 4'b1001;
    cycle(1);
    check("wrap_id3", 32'(rsp_id), 32'd3);
    cycle(1);
    check("wrap_id0", 32'(rsp_id), 32'd0);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      req_valid = NREQ'($urandom);
      rsp_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < NREQ; i++) set_ops(i, $urandom_range(0, 15), $urandom_range(0, 15));
      cycle(1);
    end

    // Reset mid-stream while a response is valid
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    cycle(1);
    check("pre_reset_valid", 32'(rsp_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid");
    @(negedge clk);
    check_reset_outputs("mid_held");
    rst_n = 1'b1;
    model_reset();
    cycle(1);

    // Counter wrap: run fast up to just below 16'hFFFF, then check across it
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    while (m_cnt != 65533) cycle(0);
    for (int n = 0; n < 5; n++) cycle(1);
    check("cnt_wrapped", 32'(issue_cnt), 32'd2);

    check("fair_max_wait_ok", 32'(max_wait <= NREQ - 1), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
